// File: rtl/memb_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// memb_ctrl_pkg
//   Shared definitions for the memory-buffer controller: default sizes,
//   controller FSM state encoding, RV32 funct3 load/store codes, and small
//   helpers for alignment checking and byte-enable generation.
// -----------------------------------------------------------------------------
package memb_ctrl_pkg;

    localparam int MEMB_LEN_DFLT = 4;                      // buffer entries
    localparam int MEMB_OFF      = $clog2(MEMB_LEN_DFLT);  // pointer width
    localparam int EXEC_LEN_DFLT = 4;                      // enqueue lanes
    localparam int XLEN_DFLT     = 32;                     // data/address width

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2
    } memb_state_e;

    // Loads
    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    // Stores
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    // funct3[1:0] encodes the access size for both loads and stores.
    function automatic logic is_misaligned(input logic [2:0] funct3, input logic [1:0] off);
        case (funct3[1:0])
            2'b01:   return off[0];
            2'b10:   return off != 2'b00;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [3:0] byte_en(input logic [2:0] funct3, input logic [1:0] off);
        case (funct3[1:0])
            2'b00:   return 4'b0001 << off;
            2'b01:   return 4'b0011 << off;
            default: return 4'b1111;
        endcase
    endfunction

endpackage

// File: rtl/memb_ctrl_if.sv
// -----------------------------------------------------------------------------
// memb_ctrl_if
//   Data-bus request/grant/read-valid handshake.
//   master (controller): drives dbus_req, dbus_we, dbus_addr, dbus_wdata,
//                        dbus_be; samples dbus_gnt, dbus_rvld, dbus_rdata.
//   slave  (bus side):   the mirror image.
// -----------------------------------------------------------------------------
interface memb_ctrl_if #(
    parameter int XLEN = memb_ctrl_pkg::XLEN_DFLT
) ();

    logic            dbus_req;
    logic            dbus_we;
    logic [XLEN-1:0] dbus_addr;
    logic [XLEN-1:0] dbus_wdata;
    logic [3:0]      dbus_be;
    logic            dbus_gnt;
    logic            dbus_rvld;
    logic [XLEN-1:0] dbus_rdata;

    modport master (
        output dbus_req, dbus_we, dbus_addr, dbus_wdata, dbus_be,
        input  dbus_gnt, dbus_rvld, dbus_rdata
    );

    modport slave (
        input  dbus_req, dbus_we, dbus_addr, dbus_wdata, dbus_be,
        output dbus_gnt, dbus_rvld, dbus_rdata
    );

endinterface

// File: rtl/memb_fifo.sv
// -----------------------------------------------------------------------------
// memb_fifo
//   Circular buffer of pending load/store operations. Up to EXEC_LEN entries
//   are written per cycle (set lanes packed in ascending order from the tail);
//   one entry is consumed per cycle from the head.
//   Ports:
//     clk, rst                 clock, async active-low reset
//     wr_vld/store/funct3/rd/addr/wdata   per-lane enqueue fields
//     rd_en                    consume the head entry this cycle
//     head_*                   current head entry, head_vld when non-empty
//     overflow                 an enqueue was dropped this cycle
// -----------------------------------------------------------------------------
module memb_fifo
    import memb_ctrl_pkg::*;
#(
    parameter int MEMB_LEN = MEMB_LEN_DFLT,
    parameter int EXEC_LEN = EXEC_LEN_DFLT,
    parameter int XLEN     = XLEN_DFLT
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [EXEC_LEN-1:0]      wr_vld,
    input  logic [EXEC_LEN-1:0]      wr_store,
    input  logic [EXEC_LEN*3-1:0]    wr_funct3,
    input  logic [EXEC_LEN*5-1:0]    wr_rd,
    input  logic [EXEC_LEN*XLEN-1:0] wr_addr,
    input  logic [EXEC_LEN*XLEN-1:0] wr_wdata,
    input  logic                     rd_en,
    output logic                     head_vld,
    output logic                     head_store,
    output logic [2:0]               head_funct3,
    output logic [4:0]               head_rd,
    output logic [XLEN-1:0]          head_addr,
    output logic [XLEN-1:0]          head_wdata,
    output logic                     overflow
);

    localparam int PTR_W = $clog2(MEMB_LEN);
    localparam int CNT_W = $clog2(MEMB_LEN + 1);
    localparam int SUM_W = $clog2(MEMB_LEN + EXEC_LEN + 1) + 1;

    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [CNT_W-1:0] count;

    logic             st_q    [MEMB_LEN];
    logic [2:0]       f3_q    [MEMB_LEN];
    logic [4:0]       rd_q    [MEMB_LEN];
    logic [XLEN-1:0]  addr_q  [MEMB_LEN];
    logic [XLEN-1:0]  wdata_q [MEMB_LEN];

    logic [EXEC_LEN-1:0] lane_we;
    logic [PTR_W-1:0]    lane_idx [EXEC_LEN];
    logic [SUM_W-1:0]    free_slots;
    logic [SUM_W-1:0]    n_acc;

    // A retiring head frees its slot in the same cycle, so a full buffer can
    // still accept one entry when it is also retiring.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // leaves it unassigned (which would infer a latch).
        free_slots = SUM_W'(MEMB_LEN) - SUM_W'(count) + SUM_W'(rd_en);
        n_acc      = '0;
        lane_we    = '0;
        overflow   = 1'b0;
        for (int i = 0; i < EXEC_LEN; i++) begin
            // NOTE: n_acc is a blocking running sum so each lane sees the
            // lanes below it; registered state elsewhere uses <= only.
            lane_idx[i] = PTR_W'(SUM_W'(tail) + n_acc);
            if (wr_vld[i]) begin
                if (n_acc < free_slots) begin
                    lane_we[i] = 1'b1;
                    n_acc      = n_acc + SUM_W'(1);
                end else begin
                    overflow = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (rd_en) begin
                head <= head + PTR_W'(1);
            end
            tail  <= PTR_W'(SUM_W'(tail) + n_acc);
            count <= CNT_W'(SUM_W'(count) + n_acc - SUM_W'(rd_en));
        end
    end

    // NOTE: the entry storage is deliberately not reset; occupancy is
    // tracked by count, so clearing the pointers flushes the buffer.
    always_ff @(posedge clk) begin
        for (int i = 0; i < EXEC_LEN; i++) begin
            if (lane_we[i]) begin
                st_q[lane_idx[i]]    <= wr_store[i];
                f3_q[lane_idx[i]]    <= wr_funct3[i*3 +: 3];
                rd_q[lane_idx[i]]    <= wr_rd[i*5 +: 5];
                addr_q[lane_idx[i]]  <= wr_addr[i*XLEN +: XLEN];
                wdata_q[lane_idx[i]] <= wr_wdata[i*XLEN +: XLEN];
            end
        end
    end

    assign head_vld    = count != '0;
    assign head_store  = st_q[head];
    assign head_funct3 = f3_q[head];
    assign head_rd     = rd_q[head];
    assign head_addr   = addr_q[head];
    assign head_wdata  = wdata_q[head];

endmodule

// File: rtl/memb_ctrl.sv
// -----------------------------------------------------------------------------
// memb_ctrl
//   Memory-buffer controller: queues in-order loads/stores from the exec
//   lanes, executes them one at a time over the data bus, and reports each
//   retirement with a registered release/writeback pulse.
//   Ports:
//     clk, rst                       clock, async active-low reset
//     mem_vld/store/funct3/rd/addr/wdata   per-lane enqueue
//     dbus (memb_ctrl_if.master)     data-bus handshake
//     mem_release, mem_sel           one slot freed, register to unlock
//     wb_vld, wb_rd, wb_data         load writeback
//     memb_err                       sticky overflow/misalignment flag
// -----------------------------------------------------------------------------
module memb_ctrl
    import memb_ctrl_pkg::*;
#(
    parameter int MEMB_LEN = MEMB_LEN_DFLT,
    parameter int EXEC_LEN = EXEC_LEN_DFLT,
    parameter int XLEN     = XLEN_DFLT
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [EXEC_LEN-1:0]      mem_vld,
    input  logic [EXEC_LEN-1:0]      mem_store,
    input  logic [EXEC_LEN*3-1:0]    mem_funct3,
    input  logic [EXEC_LEN*5-1:0]    mem_rd,
    input  logic [EXEC_LEN*XLEN-1:0] mem_addr,
    input  logic [EXEC_LEN*XLEN-1:0] mem_wdata,
    memb_ctrl_if.master              dbus,
    output logic                     mem_release,
    output logic [4:0]               mem_sel,
    output logic                     wb_vld,
    output logic [4:0]               wb_rd,
    output logic [XLEN-1:0]          wb_data,
    output logic                     memb_err
);

    logic            head_vld;
    logic            head_store;
    logic [2:0]      head_funct3;
    logic [4:0]      head_rd;
    logic [XLEN-1:0] head_addr;
    logic [XLEN-1:0] head_wdata;
    logic            overflow;

    memb_state_e     state;
    memb_state_e     state_nx;
    logic            retire;
    logic [1:0]      off;
    logic            mis;
    logic            wb_take;
    logic [XLEN-1:0] ld_shift;
    logic [XLEN-1:0] ld_data;

    memb_fifo #(
        .MEMB_LEN (MEMB_LEN),
        .EXEC_LEN (EXEC_LEN),
        .XLEN     (XLEN)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .wr_vld      (mem_vld),
        .wr_store    (mem_store),
        .wr_funct3   (mem_funct3),
        .wr_rd       (mem_rd),
        .wr_addr     (mem_addr),
        .wr_wdata    (mem_wdata),
        .rd_en       (retire),
        .head_vld    (head_vld),
        .head_store  (head_store),
        .head_funct3 (head_funct3),
        .head_rd     (head_rd),
        .head_addr   (head_addr),
        .head_wdata  (head_wdata),
        .overflow    (overflow)
    );

    assign off = head_addr[1:0];
    assign mis = is_misaligned(head_funct3, off);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Misaligned heads never reach REQ, so mis only matters in IDLE.
    always_comb begin
        state_nx = state;
        retire   = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (head_vld) begin
                    if (mis) retire   = 1'b1;
                    else     state_nx = ST_REQ;
                end
            end
            ST_REQ: begin
                if (dbus.dbus_gnt) begin
                    if (head_store) begin
                        retire   = 1'b1;
                        state_nx = ST_IDLE;
                    end else begin
                        state_nx = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                if (dbus.dbus_rvld) begin
                    retire   = 1'b1;
                    state_nx = ST_IDLE;
                end
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    // Bus outputs follow the head entry while requesting and are zero
    // otherwise; the head cannot change until retirement, so they stay
    // stable through a grant stall.
    always_comb begin
        dbus.dbus_req   = 1'b0;
        dbus.dbus_we    = 1'b0;
        dbus.dbus_addr  = '0;
        dbus.dbus_wdata = '0;
        dbus.dbus_be    = '0;
        if (state == ST_REQ) begin
            dbus.dbus_req   = 1'b1;
            dbus.dbus_we    = head_store;
            dbus.dbus_addr  = {head_addr[XLEN-1:2], 2'b00};
            dbus.dbus_wdata = head_wdata << {off, 3'b000};
            dbus.dbus_be    = byte_en(head_funct3, off);
        end
    end

    always_comb begin
        ld_shift = dbus.dbus_rdata >> {off, 3'b000};
        case (head_funct3)
            F3_LB:   ld_data = {{(XLEN-8){ld_shift[7]}},   ld_shift[7:0]};
            F3_LH:   ld_data = {{(XLEN-16){ld_shift[15]}}, ld_shift[15:0]};
            F3_LBU:  ld_data = {{(XLEN-8){1'b0}},          ld_shift[7:0]};
            F3_LHU:  ld_data = {{(XLEN-16){1'b0}},         ld_shift[15:0]};
            default: ld_data = ld_shift;
        endcase
    end

    // Only a load retiring out of WAIT produces writeback data.
    assign wb_take = retire && (state == ST_WAIT) && (head_rd != 5'd0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem_release <= 1'b0;
            mem_sel     <= '0;
            wb_vld      <= 1'b0;
            wb_rd       <= '0;
            wb_data     <= '0;
            memb_err    <= 1'b0;
        end else begin
            mem_release <= retire;
            mem_sel     <= (retire && !head_store) ? head_rd : 5'd0;
            wb_vld      <= wb_take;
            wb_rd       <= wb_take ? head_rd : 5'd0;
            wb_data     <= wb_take ? ld_data : '0;
            if (overflow || (retire && mis)) begin
                memb_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_memb_ctrl.sv
// -----------------------------------------------------------------------------
// tb_memb_ctrl
//   Self-checking bench for memb_ctrl. Directed operations push expected bus
//   transactions and expected release pulses into queues; a bus model and a
//   release monitor pop and compare as the DUT presents them.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_memb_ctrl;
    import memb_ctrl_pkg::*;

    localparam int MEMB_LEN = 4;
    localparam int EXEC_LEN = 4;
    localparam int XLEN     = 32;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic [EXEC_LEN-1:0]      mem_vld;
    logic [EXEC_LEN-1:0]      mem_store;
    logic [EXEC_LEN*3-1:0]    mem_funct3;
    logic [EXEC_LEN*5-1:0]    mem_rd;
    logic [EXEC_LEN*XLEN-1:0] mem_addr;
    logic [EXEC_LEN*XLEN-1:0] mem_wdata;
    logic                     mem_release;
    logic [4:0]               mem_sel;
    logic                     wb_vld;
    logic [4:0]               wb_rd;
    logic [XLEN-1:0]          wb_data;
    logic                     memb_err;

    memb_ctrl_if #(.XLEN(XLEN)) dbus ();

    memb_ctrl #(
        .MEMB_LEN (MEMB_LEN),
        .EXEC_LEN (EXEC_LEN),
        .XLEN     (XLEN)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .mem_vld     (mem_vld),
        .mem_store   (mem_store),
        .mem_funct3  (mem_funct3),
        .mem_rd      (mem_rd),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .dbus        (dbus.master),
        .mem_release (mem_release),
        .mem_sel     (mem_sel),
        .wb_vld      (wb_vld),
        .wb_rd       (wb_rd),
        .wb_data     (wb_data),
        .memb_err    (memb_err)
    );

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          gnt_dly;
        int          rvld_dly;
        bit          abort;
    } bus_exp_t;

    typedef struct {
        logic [4:0]  sel;
        logic        wbv;
        logic [31:0] data;
    } rel_exp_t;

    bus_exp_t bus_q[$];
    rel_exp_t rel_q[$];

    int checks   = 0;
    int errors   = 0;
    int cyc      = 0;
    int req_cyc  = 0;
    int rel_cyc  = 0;
    bit bus_busy = 1'b0;
    bit in_wait  = 1'b0;
    bit resumed  = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic expect_bus(input logic we, input logic [31:0] addr, input logic [3:0] be,
                              input logic [31:0] wdata, input logic [31:0] rdata,
                              input int gnt_dly, input int rvld_dly, input bit abort);
        bus_exp_t e;
        e.we = we; e.addr = addr; e.be = be; e.wdata = wdata; e.rdata = rdata;
        e.gnt_dly = gnt_dly; e.rvld_dly = rvld_dly; e.abort = abort;
        bus_q.push_back(e);
    endtask

    task automatic expect_rel(input logic [4:0] sel, input logic wbv, input logic [31:0] data);
        rel_exp_t r;
        r.sel = sel; r.wbv = wbv; r.data = data;
        rel_q.push_back(r);
    endtask

    task automatic set_lane(input int i, input logic st, input logic [2:0] f3, input logic [4:0] rd,
                            input logic [31:0] addr, input logic [31:0] wd);
        mem_vld[i]              = 1'b1;
        mem_store[i]            = st;
        mem_funct3[i*3 +: 3]    = f3;
        mem_rd[i*5 +: 5]        = rd;
        mem_addr[i*XLEN +: XLEN]  = addr;
        mem_wdata[i*XLEN +: XLEN] = wd;
    endtask

    task automatic clear_lanes();
        mem_vld = '0; mem_store = '0; mem_funct3 = '0;
        mem_rd = '0; mem_addr = '0; mem_wdata = '0;
    endtask

    // Call at a negedge after set_lane: holds the lanes for one clock edge.
    task automatic fire();
        @(negedge clk);
        clear_lanes();
    endtask

    task automatic drain();
        for (int n = 0; n < 300 && (bus_q.size() != 0 || rel_q.size() != 0 || bus_busy); n++)
            @(negedge clk);
        check("drain_bus_q", bus_q.size(), 0);
        check("drain_rel_q", rel_q.size(), 0);
        repeat (3) @(negedge clk);
    endtask

    // Bus model: grants after the programmed stall, returns read data, and
    // checks the request fields on every cycle the request is held.
    initial begin : bus_model
        bus_exp_t e;
        dbus.dbus_gnt   = 1'b0;
        dbus.dbus_rvld  = 1'b0;
        dbus.dbus_rdata = '0;
        forever begin
            @(negedge clk);
            if (rst && dbus.dbus_req) begin
                if (bus_q.size() == 0) begin
                    check("unexpected_req", {31'd0, dbus.dbus_req}, 32'd0);
                end else begin
                    bus_busy = 1'b1;
                    e = bus_q.pop_front();
                    req_cyc = cyc;
                    for (int k = 0; k <= e.gnt_dly; k++) begin
                        if (k > 0) @(negedge clk);
                        check("bus_req_held", {31'd0, dbus.dbus_req}, 32'd1);
                        check("bus_we", {31'd0, dbus.dbus_we}, {31'd0, e.we});
                        check("bus_addr", dbus.dbus_addr, e.addr);
                        check("bus_be", {28'd0, dbus.dbus_be}, {28'd0, e.be});
                        if (e.we) check("bus_wdata", dbus.dbus_wdata, e.wdata);
                    end
                    dbus.dbus_gnt = 1'b1;
                    @(negedge clk);
                    dbus.dbus_gnt = 1'b0;
                    check("req_drop_after_gnt", {31'd0, dbus.dbus_req}, 32'd0);
                    if (!e.we) begin
                        if (e.abort) begin
                            in_wait = 1'b1;
                            for (int n = 0; n < 100 && !resumed; n++) @(negedge clk);
                        end else begin
                            repeat (e.rvld_dly - 1) @(negedge clk);
                        end
                        dbus.dbus_rvld  = 1'b1;
                        dbus.dbus_rdata = e.rdata;
                        @(negedge clk);
                        dbus.dbus_rvld  = 1'b0;
                        dbus.dbus_rdata = '0;
                        check("req_drop_after_rvld", {31'd0, dbus.dbus_req}, 32'd0);
                    end
                    bus_busy = 1'b0;
                end
            end
        end
    end

    // Release monitor.
    initial begin : monitor
        rel_exp_t r;
        bit prev_rel;
        prev_rel = 1'b0;
        forever begin
            @(negedge clk);
            if (mem_release) begin
                check("release_gap", {31'd0, prev_rel}, 32'd0);
                rel_cyc = cyc;
                if (rel_q.size() == 0) begin
                    check("unexpected_release", {31'd0, mem_release}, 32'd0);
                end else begin
                    r = rel_q.pop_front();
                    check("mem_sel", {27'd0, mem_sel}, {27'd0, r.sel});
                    check("wb_vld", {31'd0, wb_vld}, {31'd0, r.wbv});
                    if (r.wbv) begin
                        check("wb_rd", {27'd0, wb_rd}, {27'd0, r.sel});
                        check("wb_data", wb_data, r.data);
                    end
                end
            end else if (wb_vld) begin
                check("stray_wb_vld", {31'd0, wb_vld}, 32'd0);
            end
            prev_rel = mem_release;
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin : stim
        int enq_cyc;
        clear_lanes();

        // Reset values.
        repeat (3) @(negedge clk);
        check("rst_dbus_req", {31'd0, dbus.dbus_req}, 32'd0);
        check("rst_dbus_be", {28'd0, dbus.dbus_be}, 32'd0);
        check("rst_dbus_addr", dbus.dbus_addr, 32'd0);
        check("rst_mem_release", {31'd0, mem_release}, 32'd0);
        check("rst_mem_sel", {27'd0, mem_sel}, 32'd0);
        check("rst_wb_vld", {31'd0, wb_vld}, 32'd0);
        check("rst_wb_data", wb_data, 32'd0);
        check("rst_memb_err", {31'd0, memb_err}, 32'd0);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        // Single LW: grant in the first request cycle, read data two later.
        expect_bus(1'b0, 32'h100, 4'hF, 32'h0, 32'hDEADBEEF, 0, 2, 1'b0);
        expect_rel(5'd5, 1'b1, 32'hDEADBEEF);
        enq_cyc = cyc;
        set_lane(0, 1'b0, F3_LW, 5'd5, 32'h100, 32'h0);
        fire();
        drain();
        check("lw_req_latency", req_cyc - enq_cyc, 2);
        check("lw_release_latency", rel_cyc - enq_cyc, 5);

        // Four-lane burst SB/SH/SW/LBU.
        expect_bus(1'b1, 32'h200, 4'h8, 32'hA500_0000, 32'h0, 0, 0, 1'b0);
        expect_bus(1'b1, 32'h200, 4'hC, 32'h1234_0000, 32'h0, 0, 0, 1'b0);
        expect_bus(1'b1, 32'h200, 4'hF, 32'hCAFE_F00D, 32'h0, 0, 0, 1'b0);
        expect_bus(1'b0, 32'h200, 4'h2, 32'h0, 32'h0000_8000, 1, 1, 1'b0);
        expect_rel(5'd0, 1'b0, 32'h0);
        expect_rel(5'd0, 1'b0, 32'h0);
        expect_rel(5'd0, 1'b0, 32'h0);
        expect_rel(5'd9, 1'b1, 32'h0000_0080);
        set_lane(0, 1'b1, F3_SB,  5'd0, 32'h203, 32'h0000_00A5);
        set_lane(1, 1'b1, F3_SH,  5'd0, 32'h202, 32'h0000_1234);
        set_lane(2, 1'b1, F3_SW,  5'd0, 32'h200, 32'hCAFE_F00D);
        set_lane(3, 1'b0, F3_LBU, 5'd9, 32'h201, 32'h0);
        fire();
        drain();

        // Load extension: LB, LH, LHU and an LW to x0.
        expect_bus(1'b0, 32'h0, 4'h8, 32'h0, 32'h8012_3456, 0, 1, 1'b0);
        expect_bus(1'b0, 32'h0, 4'hC, 32'h0, 32'h8001_7777, 0, 1, 1'b0);
        expect_bus(1'b0, 32'h0, 4'h3, 32'h0, 32'h0000_F00F, 0, 1, 1'b0);
        expect_bus(1'b0, 32'h8, 4'hF, 32'h0, 32'h1234_5678, 0, 1, 1'b0);
        expect_rel(5'd12, 1'b1, 32'hFFFF_FF80);
        expect_rel(5'd13, 1'b1, 32'hFFFF_8001);
        expect_rel(5'd14, 1'b1, 32'h0000_F00F);
        expect_rel(5'd0,  1'b0, 32'h0);
        set_lane(0, 1'b0, F3_LB,  5'd12, 32'h3, 32'h0);
        set_lane(1, 1'b0, F3_LH,  5'd13, 32'h2, 32'h0);
        set_lane(2, 1'b0, F3_LHU, 5'd14, 32'h0, 32'h0);
        set_lane(3, 1'b0, F3_LW,  5'd0,  32'h8, 32'h0);
        fire();
        drain();

        // Grant stall on a full buffer, plus an overflowing enqueue.
        expect_bus(1'b1, 32'h300, 4'hF, 32'h1111_2222, 32'h0, 10, 0, 1'b0);
        expect_bus(1'b1, 32'h304, 4'hF, 32'h3333_4444, 32'h0, 0, 0, 1'b0);
        expect_bus(1'b1, 32'h308, 4'hF, 32'h5555_6666, 32'h0, 0, 0, 1'b0);
        expect_bus(1'b1, 32'h30C, 4'hF, 32'h7777_8888, 32'h0, 0, 0, 1'b0);
        repeat (4) expect_rel(5'd0, 1'b0, 32'h0);
        set_lane(0, 1'b1, F3_SW, 5'd0, 32'h300, 32'h1111_2222);
        set_lane(1, 1'b1, F3_SW, 5'd0, 32'h304, 32'h3333_4444);
        set_lane(2, 1'b1, F3_SW, 5'd0, 32'h308, 32'h5555_6666);
        set_lane(3, 1'b1, F3_SW, 5'd0, 32'h30C, 32'h7777_8888);
        fire();
        repeat (3) @(negedge clk);
        set_lane(0, 1'b1, F3_SW, 5'd0, 32'h400, 32'hBAD0_BAD0);
        fire();
        drain();
        check("overflow_err", {31'd0, memb_err}, 32'd1);

        // Reset while waiting for read data; the late response is ignored.
        in_wait = 1'b0;
        resumed = 1'b0;
        expect_bus(1'b0, 32'h40, 4'hF, 32'h0, 32'hBADB_AD00, 0, 0, 1'b1);
        set_lane(0, 1'b0, F3_LW, 5'd3, 32'h40, 32'h0);
        fire();
        for (int n = 0; n < 50 && !in_wait; n++) @(negedge clk);
        check("reach_wait", {31'd0, in_wait}, 32'd1);
        rst = 1'b0;
        @(negedge clk);
        check("rst_mid_release", {31'd0, mem_release}, 32'd0);
        check("rst_mid_err", {31'd0, memb_err}, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        resumed = 1'b1;
        for (int n = 0; n < 50 && bus_busy; n++) @(negedge clk);
        repeat (3) @(negedge clk);
        check("post_rst_count", {29'd0, dut.u_fifo.count}, 32'd0);
        check("post_rst_req", {31'd0, dbus.dbus_req}, 32'd0);
        expect_bus(1'b0, 32'h44, 4'hF, 32'h0, 32'h55AA_55AA, 0, 1, 1'b0);
        expect_rel(5'd4, 1'b1, 32'h55AA_55AA);
        set_lane(0, 1'b0, F3_LW, 5'd4, 32'h44, 32'h0);
        fire();
        drain();
        check("post_rst_err", {31'd0, memb_err}, 32'd0);

        // Misaligned LW: no bus access, error, release with its rd.
        expect_rel(5'd7, 1'b0, 32'h0);
        set_lane(0, 1'b0, F3_LW, 5'd7, 32'h102, 32'h0);
        fire();
        drain();
        check("misaligned_err", {31'd0, memb_err}, 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
